// File: rtl/rr_wormhole_arbiter_pkg.sv
// rtl/rr_wormhole_arbiter_pkg.sv - shared NoC types, constants and helpers
// Purpose: flit type, arbiter state encoding and an index-width helper shared
// by the arbiter, its picker and other router allocators.
package noc_pkg;

  localparam int FLIT_W_DEF = 32;

  typedef struct packed {
    logic [FLIT_W_DEF-1:0] data;
    logic                  last;
  } flit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero for single-input instances.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_wormhole_arbiter_if.sv
// rtl/rr_wormhole_arbiter_if.sv - flit arbiter handshake bundle
// Purpose: groups the per-input flit channels and the single output link.
//   slave  : arbiter side (consumes in_*, out_ready; drives in_ready, out_*, grant_idx, locked)
//   master : environment side (the mirror image)
interface rr_wormhole_arbiter_if
  import noc_pkg::*;
#(
  parameter int N_IN   = 5,
  parameter int FLIT_W = FLIT_W_DEF
);

  localparam int IDX_W = clog2_min1(N_IN);

  logic [FLIT_W-1:0] in_data [N_IN];
  logic [N_IN-1:0]   in_valid;
  logic [N_IN-1:0]   in_last;
  logic [N_IN-1:0]   in_ready;
  logic [FLIT_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [IDX_W-1:0]  grant_idx;
  logic              locked;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant_idx, locked
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant_idx, locked
  );

endinterface

// File: rtl/rr_wormhole_arbiter_picker.sv
// rtl/rr_wormhole_arbiter_picker.sv - combinational round-robin priority picker
// Purpose: returns the first asserted request scanning ptr, ptr+1, ... with wrap.
//   req_i   : request vector
//   ptr_i   : highest-priority index (must be < N_IN)
//   sel_o   : selected index (0 when nothing found)
//   found_o : at least one request asserted
module rr_priority_picker
  import noc_pkg::*;
#(
  parameter int N_IN  = 5,
  parameter int IDX_W = clog2_min1(N_IN)
) (
  input  logic [N_IN-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] sel_o,
  output logic             found_o
);

  always_comb begin
    int idx;
    sel_o   = '0;
    found_o = 1'b0;
    idx     = int'(ptr_i);
    for (int k = 0; k < N_IN; k++) begin
      if (!found_o && req_i[idx]) begin
        found_o = 1'b1;
        sel_o   = idx[IDX_W-1:0];
      end
      // Explicit wrap keeps the scan in range for non-power-of-2 N_IN.
      idx = (idx == N_IN - 1) ? 0 : idx + 1;
    end
  end

endmodule

// File: rtl/rr_wormhole_arbiter.sv
// rtl/rr_wormhole_arbiter.sv - round-robin N-to-1 wormhole flit arbiter
// Purpose: picks one input per flit, optionally holds it until the tail flit,
// and drives a single registered output stage with valid/ready flow control.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport of rr_wormhole_arbiter_if
module rr_wormhole_arbiter
  import noc_pkg::*;
#(
  parameter int N_IN         = 5,
  parameter int FLIT_W       = FLIT_W_DEF,
  parameter int LOCK_PACKETS = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  rr_wormhole_arbiter_if.slave bus
);

  localparam int IDX_W = clog2_min1(N_IN);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [FLIT_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [IDX_W-1:0]  grant_q;

  logic              load_en;
  logic [N_IN-1:0]   req_eff;
  logic [IDX_W-1:0]  pick_ptr;
  logic [IDX_W-1:0]  sel;
  logic              sel_found;
  logic              sel_last;
  logic              xfer;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(N_IN - 1)) ? '0 : x + 1'b1;
  endfunction

  // The output slot is free when empty or being drained this cycle.
  assign load_en = !out_valid_q || bus.out_ready;

  // While locked, only the owner may request; starting the scan at the owner
  // makes the picker return it directly.
  assign req_eff  = (state_q == ST_LOCKED) ? (bus.in_valid & (N_IN'(1) << owner_q))
                                           : bus.in_valid;
  assign pick_ptr = (state_q == ST_LOCKED) ? owner_q : ptr_q;

  rr_priority_picker #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i   (req_eff),
    .ptr_i   (pick_ptr),
    .sel_o   (sel),
    .found_o (sel_found)
  );

  assign xfer         = load_en && sel_found;
  assign sel_last     = bus.in_last[sel];
  assign bus.in_ready = xfer ? (N_IN'(1) << sel) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if ((LOCK_PACKETS != 0) && !sel_last) begin
            state_d = ST_LOCKED;
            owner_d = sel;
          end else begin
            ptr_d = wrap_inc(sel);
          end
        end
      end
      ST_LOCKED: begin
        if (xfer && sel_last) begin
          state_d = ST_IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      grant_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      if (load_en) begin
        out_valid_q <= sel_found;
        // Payload fields only move when a flit is actually taken.
        if (sel_found) begin
          out_data_q <= bus.in_data[sel];
          out_last_q <= sel_last;
          grant_q    <= sel;
        end
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.grant_idx = grant_q;
  assign bus.locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rr_wormhole_arbiter.sv
// tb/tb_rr_wormhole_arbiter.sv - self-checking bench for rr_wormhole_arbiter
module tb_rr_wormhole_arbiter;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] v_valid;
  logic [N-1:0] v_last;
  logic         v_ordy;
  logic [31:0]  v_data [N];

  rr_wormhole_arbiter_if #(.N_IN(N), .FLIT_W(32)) if_a ();
  rr_wormhole_arbiter_if #(.N_IN(N), .FLIT_W(32)) if_b ();

  assign if_a.in_valid  = v_valid;
  assign if_a.in_last   = v_last;
  assign if_a.out_ready = v_ordy;
  assign if_a.in_data   = v_data;
  assign if_b.in_valid  = v_valid;
  assign if_b.in_last   = v_last;
  assign if_b.out_ready = v_ordy;
  assign if_b.in_data   = v_data;

  rr_wormhole_arbiter #(.N_IN(N), .FLIT_W(32), .LOCK_PACKETS(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  rr_wormhole_arbiter #(.N_IN(N), .FLIT_W(32), .LOCK_PACKETS(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: one entry per DUT (0 = packet locking, 1 = per-flit).
  bit          m_ov     [2];
  logic [31:0] m_data   [2];
  bit          m_last   [2];
  int          m_grant  [2];
  bit          m_locked [2];
  int          m_owner  [2];
  int          m_ptr    [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ov[d] = 0; m_data[d] = '0; m_last[d] = 0; m_grant[d] = 0;
      m_locked[d] = 0; m_owner[d] = 0; m_ptr[d] = 0;
    end
  endtask

  task automatic model_pick(input int d, output bit load, output bit found, output int sel);
    load  = !m_ov[d] || v_ordy;
    found = 0;
    sel   = 0;
    if (m_locked[d]) begin
      found = v_valid[m_owner[d]];
      sel   = m_owner[d];
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr[d] + k) % N;
        if (!found && v_valid[j]) begin
          found = 1;
          sel   = j;
        end
      end
    end
  endtask

  task automatic model_update(input int d);
    bit load, found;
    int sel;
    model_pick(d, load, found, sel);
    if (load) begin
      m_ov[d] = found;
      if (found) begin
        m_data[d]  = v_data[sel];
        m_last[d]  = v_last[sel];
        m_grant[d] = sel;
      end
    end
    if (load && found) begin
      if (m_locked[d]) begin
        if (v_last[sel]) begin
          m_locked[d] = 0;
          m_ptr[d]    = (m_owner[d] + 1) % N;
        end
      end else if (d == 0 && !v_last[sel]) begin
        m_locked[d] = 1;
        m_owner[d]  = sel;
      end else begin
        m_ptr[d] = (sel + 1) % N;
      end
    end
  endtask

  task automatic mcheck(input int d, input logic [N-1:0] rdy, input logic ov,
                        input logic [31:0] dat, input logic lst,
                        input logic [2:0] gr, input logic lk);
    bit load, found;
    int sel;
    string p;
    p = (d == 0) ? "a" : "b";
    model_pick(d, load, found, sel);
    chk({p, ".in_ready"}, 32'(rdy), (load && found) ? (32'd1 << sel) : 32'd0);
    chk({p, ".out_valid"}, 32'(ov), 32'(m_ov[d]));
    chk({p, ".locked"}, 32'(lk), 32'(m_locked[d]));
    if (m_ov[d]) begin
      chk({p, ".out_data"}, dat, m_data[d]);
      chk({p, ".out_last"}, 32'(lst), 32'(m_last[d]));
      chk({p, ".grant_idx"}, 32'(gr), 32'(m_grant[d]));
    end
  endtask

  // Called just after inputs change at the falling edge.
  task automatic model_check();
    #1;
    mcheck(0, if_a.in_ready, if_a.out_valid, if_a.out_data, if_a.out_last, if_a.grant_idx, if_a.locked);
    mcheck(1, if_b.in_ready, if_b.out_valid, if_b.out_data, if_b.out_last, if_b.grant_idx, if_b.locked);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      model_update(0);
      model_update(1);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         ordy;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    int           exp_grant;
    logic         exp_locked;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int g_seq [3];

    tbl[0]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b0, 0, 1'b0};
    tbl[1]  = '{5'b11111, 5'b11111, 1'b1, 5'b00010, 1'b1, 0, 1'b0};
    tbl[2]  = '{5'b11111, 5'b11111, 1'b1, 5'b00100, 1'b1, 1, 1'b0};
    tbl[3]  = '{5'b11111, 5'b11111, 1'b1, 5'b01000, 1'b1, 2, 1'b0};
    tbl[4]  = '{5'b11111, 5'b11111, 1'b1, 5'b10000, 1'b1, 3, 1'b0};
    tbl[5]  = '{5'b11111, 5'b11111, 1'b1, 5'b00001, 1'b1, 4, 1'b0};
    tbl[6]  = '{5'b10101, 5'b11011, 1'b1, 5'b00100, 1'b1, 0, 1'b0};
    tbl[7]  = '{5'b10101, 5'b11011, 1'b1, 5'b00100, 1'b1, 2, 1'b1};
    tbl[8]  = '{5'b10101, 5'b11111, 1'b1, 5'b00100, 1'b1, 2, 1'b1};
    tbl[9]  = '{5'b10101, 5'b11111, 1'b1, 5'b10000, 1'b1, 2, 1'b0};
    tbl[10] = '{5'b00001, 5'b11111, 1'b1, 5'b00001, 1'b1, 4, 1'b0};
    tbl[11] = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b1, 0, 1'b0};
    tbl[12] = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 0, 1'b0};
    tbl[13] = '{5'b00010, 5'b11111, 1'b1, 5'b00010, 1'b0, 0, 1'b0};
    tbl[14] = '{5'b00100, 5'b11111, 1'b0, 5'b00000, 1'b1, 1, 1'b0};
    tbl[15] = '{5'b00100, 5'b11111, 1'b0, 5'b00000, 1'b1, 1, 1'b0};
    tbl[16] = '{5'b00100, 5'b11111, 1'b1, 5'b00100, 1'b1, 1, 1'b0};
    tbl[17] = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b1, 2, 1'b0};
    tbl[18] = '{5'b00000, 5'b11111, 1'b1, 5'b00000, 1'b0, 0, 1'b0};

    for (int i = 0; i < N; i++) v_data[i] = 32'hA000_0000 + i;
    v_valid = '1;
    v_last  = '1;
    v_ordy  = 1'b1;
    model_reset();

    // Reset state with every input requesting.
    repeat (3) @(negedge clk);
    chk("rst.out_valid", 32'(if_a.out_valid), 32'd0);
    chk("rst.out_data", if_a.out_data, 32'd0);
    chk("rst.out_last", 32'(if_a.out_last), 32'd0);
    chk("rst.grant_idx", 32'(if_a.grant_idx), 32'd0);
    chk("rst.locked", 32'(if_a.locked), 32'd0);
    rst_n = 1'b1;
    chk("rel.out_valid", 32'(if_a.out_valid), 32'd0);

    // Directed table on the packet-locking instance.
    for (int i = 0; i < 19; i++) begin
      v_valid = tbl[i].valid;
      v_last  = tbl[i].last;
      v_ordy  = tbl[i].ordy;
      model_check();
      chk($sformatf("tbl%0d.in_ready", i), 32'(if_a.in_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d.out_valid", i), 32'(if_a.out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d.locked", i), 32'(if_a.locked), 32'(tbl[i].exp_locked));
      if (tbl[i].exp_ov) begin
        chk($sformatf("tbl%0d.grant_idx", i), 32'(if_a.grant_idx), 32'(tbl[i].exp_grant));
        chk($sformatf("tbl%0d.out_data", i), if_a.out_data, 32'hA000_0000 + 32'(tbl[i].exp_grant));
      end
      advance();
    end

    // Lock onto input 3, then reset mid-packet.
    v_valid = 5'b01000;
    v_last  = 5'b00000;
    v_ordy  = 1'b1;
    model_check();
    chk("lk3.in_ready", 32'(if_a.in_ready), 32'h08);
    advance();
    model_check();
    chk("lk3.locked", 32'(if_a.locked), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.locked", 32'(if_a.locked), 32'd0);
    chk("midrst.out_valid", 32'(if_a.out_valid), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Inputs 1 and 3 stream multi-flit packets: the locking arbiter sticks to
    // input 1 (scan restarts at 0), the per-flit arbiter alternates 1,3,1,3.
    v_valid = 5'b01010;
    v_last  = 5'b00000;
    g_seq[0] = 1; g_seq[1] = 3; g_seq[2] = 1;
    model_check();
    chk("post_rst.a.in_ready", 32'(if_a.in_ready), 32'h02);
    chk("ilv0.b.in_ready", 32'(if_b.in_ready), 32'h02);
    advance();
    for (int k = 1; k < 4; k++) begin
      model_check();
      chk($sformatf("ilv%0d.a.in_ready", k), 32'(if_a.in_ready), 32'h02);
      chk($sformatf("ilv%0d.b.in_ready", k), 32'(if_b.in_ready), (k % 2 == 1) ? 32'h08 : 32'h02);
      chk($sformatf("ilv%0d.b.grant_idx", k), 32'(if_b.grant_idx), 32'(g_seq[k-1]));
      advance();
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      v_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        v_last[i] = ($urandom_range(0, 9) < 4);
        v_data[i] = $urandom;
      end
      v_ordy = ($urandom_range(0, 3) != 0);
      model_check();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
